// File: rtl/regs_scoreboard_pkg.sv
// Shared constants and width helpers for the register-hazard scoreboard.
package regs_scoreboard_pkg;

    function automatic int unsigned addr_width(input int unsigned num_regs);
        return $clog2(num_regs);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_pending);
        return $clog2(max_pending + 1);
    endfunction

    localparam int unsigned REG_ZERO        = 0;
    localparam int unsigned DEF_NUM_REGS    = 32;
    localparam int unsigned DEF_MAX_PENDING = 3;
    localparam int unsigned DEF_AW          = addr_width(DEF_NUM_REGS);
    localparam int unsigned DEF_CW          = cnt_width(DEF_MAX_PENDING);

endpackage

// File: rtl/regs_scoreboard_counter.sv
// Saturating up/down pending-write counter for one architectural register.
module scoreboard_counter #(
    parameter int unsigned CW      = 2,
    parameter int unsigned MAX_CNT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          nonzero,
    output logic          full
);

    localparam logic [CW-1:0] MaxVal = CW'(MAX_CNT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && cnt_q != MaxVal) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec && !inc && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt     = cnt_q;
        nonzero = (cnt_q != '0);
        full    = (cnt_q == MaxVal);
    end

endmodule

// File: rtl/regs_scoreboard.sv
// Register-hazard scoreboard: per-register pending-write counters, RAW detection
// on two source operands, decode stall and sticky writeback-underflow flag.
module regs_scoreboard
    import regs_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS     = DEF_NUM_REGS,
    parameter int unsigned MAX_PENDING  = DEF_MAX_PENDING,
    parameter int unsigned R0_HARDWIRED = 1,
    parameter int unsigned WB_BYPASS    = 1,
    localparam int unsigned AW          = addr_width(NUM_REGS),
    localparam int unsigned CW          = cnt_width(MAX_PENDING)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rnum1,
    input  logic [AW-1:0] rnum2,
    input  logic          rd_en1,
    input  logic          rd_en2,
    input  logic          issue_valid,
    input  logic          issue_we,
    input  logic [AW-1:0] issue_wnum,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_wnum,
    input  logic          flush,
    output logic          busy_rnum1,
    output logic          busy_rnum2,
    output logic          stall,
    output logic          issue_accept,
    output logic          underflow_err
);

    logic [CW-1:0]       cnt [NUM_REGS];
    logic [NUM_REGS-1:0] nonzero, full, inc, dec;
    logic                underflow_err_q, underflow_err_d;
    logic                r0_rd1, r0_rd2, r0_dst, r0_wb;
    logic                hit1, hit2, hit_dst;
    logic                pend1, pend2, full_dst;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        scoreboard_counter #(
            .CW      (CW),
            .MAX_CNT (MAX_PENDING)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .clr     (flush),
            .inc     (inc[i]),
            .dec     (dec[i]),
            .cnt     (cnt[i]),
            .nonzero (nonzero[i]),
            .full    (full[i])
        );
    end

    always_comb begin
        r0_rd1 = (R0_HARDWIRED != 0) && (rnum1 == AW'(REG_ZERO));
        r0_rd2 = (R0_HARDWIRED != 0) && (rnum2 == AW'(REG_ZERO));
        r0_dst = (R0_HARDWIRED != 0) && (issue_wnum == AW'(REG_ZERO));
        r0_wb  = (R0_HARDWIRED != 0) && (wb_wnum == AW'(REG_ZERO));

        hit1    = wb_valid && (wb_wnum == rnum1) && nonzero[rnum1];
        hit2    = wb_valid && (wb_wnum == rnum2) && nonzero[rnum2];
        hit_dst = wb_valid && (wb_wnum == issue_wnum) && nonzero[issue_wnum];

        // With bypass, a retiring last write no longer counts as pending.
        pend1 = nonzero[rnum1];
        pend2 = nonzero[rnum2];
        if (WB_BYPASS != 0) begin
            if (hit1) pend1 = (cnt[rnum1] > CW'(1));
            if (hit2) pend2 = (cnt[rnum2] > CW'(1));
        end

        busy_rnum1 = rd_en1 && pend1 && !r0_rd1;
        busy_rnum2 = rd_en2 && pend2 && !r0_rd2;
        full_dst   = issue_we && full[issue_wnum] && !r0_dst && !((WB_BYPASS != 0) && hit_dst);

        stall        = issue_valid && (busy_rnum1 || busy_rnum2 || full_dst);
        issue_accept = issue_valid && !stall && !rst;
    end

    always_comb begin
        inc = '0;
        dec = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            inc[i] = issue_accept && issue_we && (issue_wnum == AW'(i));
            dec[i] = wb_valid && (wb_wnum == AW'(i)) && nonzero[i];
        end
        if (R0_HARDWIRED != 0) begin
            inc[REG_ZERO] = 1'b0;
        end
        underflow_err_d = underflow_err_q || (!flush && wb_valid && !nonzero[wb_wnum] && !r0_wb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_err_q <= 1'b0;
        end else begin
            underflow_err_q <= underflow_err_d;
        end
    end

    assign underflow_err = underflow_err_q;

endmodule
